aes_decryption: RTL and testbench

- Byte-serial AES-128 decryption core. It is the inverse counterpart of the AES encryption top level and uses the same enable/load/ready byte-stream interface.
- It accepts a 128-bit cipher key and a 128-bit ciphertext one byte per enabled cycle. It expands the key forward to round key 10, then runs the 10 inverse rounds iteratively, one round per enabled cycle, while regenerating round keys backwards.
- It streams the plaintext out one byte per enabled cycle.
- Submodules: existing subByte (32-bit, combinational, forward S-box) for the key schedule; new companion invSubByte (same port shape, inverse S-box) ×4 for the state.

---
 rtl/invSubByte.sv | 42 ++++
 rtl/subByte.sv | 41 ++++
 rtl/aes_decryption.sv | 226 ++++++++++++++++++++++
 tb/tb_aes_decryption.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/invSubByte.sv
// rtl/invSubByte.sv - inverse AES S-box applied to each byte of a 32-bit word
module invSubByte (
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, which maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Undo the affine transform first, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] y;
        y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    // One inverse S-box per byte lane.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign out_word[8*i +: 8] = inv_sbox(in_word[8*i +: 8]);
    end
endmodule

// File: rtl/subByte.sv
// rtl/subByte.sv - forward AES S-box applied to each byte of a 32-bit word
module subByte (
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, which maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // One S-box per byte lane.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign out_word[8*i +: 8] = sbox(in_word[8*i +: 8]);
    end
endmodule

// File: rtl/aes_decryption.sv
// rtl/aes_decryption.sv - byte-serial AES-128 decryption core
module aes_decryption (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] key_byte,
    input  logic [7:0] state_byte,
    output logic [7:0] state_out_byte,
    output logic       load,
    output logic       ready
);
    typedef enum logic [2:0] {IDLE, LOAD, KEXP, ROUND, OUT} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] key_q, key_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         load_q, load_d;
    logic         ready_q, ready_d;
    logic [7:0]   out_q, out_d;

    logic [31:0]  rot_src, sub_in, sub_out, rcon_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_rk, prev_rk;
    logic [127:0] isr, isb, t_blk, imc;
    logic [6:0]   byte_lsb;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Column is {row0,row1,row2,row3}; multiples 9/b/d/e built from one xtime chain per byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Row r is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-32*c-8*w -: 8] = s[127-32*((c-w+4)%4)-8*w -: 8];
            end
        end
        return r;
    endfunction

    // One S-box word serves both directions: RotWord(w3) forward, RotWord(w3^w2) backward.
    always_comb begin
        rot_src = (fsm_q == ROUND) ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
        sub_in  = {rot_src[23:0], rot_src[31:24]};
        rcon_w  = {rcon(rnd_q), 24'h000000};
    end

    subByte u_sub (
        .in_word  (sub_in),
        .out_word (sub_out)
    );

    // Forward and backward round-key steps from the current round key.
    always_comb begin
        n0      = rk_q[127:96] ^ sub_out ^ rcon_w;
        n1      = rk_q[95:64] ^ n0;
        n2      = rk_q[63:32] ^ n1;
        n3      = rk_q[31:0] ^ n2;
        next_rk = {n0, n1, n2, n3};
        prev_rk = {rk_q[127:96] ^ sub_out ^ rcon_w,
                   rk_q[127:96] ^ rk_q[95:64],
                   rk_q[95:64] ^ rk_q[63:32],
                   rk_q[63:32] ^ rk_q[31:0]};
    end

    assign isr = inv_shift_rows(st_q);

    for (genvar c = 0; c < 4; c++) begin : g_isb
        invSubByte u_isb (
            .in_word  (isr[127-32*c -: 32]),
            .out_word (isb[127-32*c -: 32])
        );
    end

    // Inverse round datapath; the key added is the one for round rnd-1.
    always_comb begin
        t_blk    = isb ^ prev_rk;
        imc      = {inv_mix_col(t_blk[127:96]), inv_mix_col(t_blk[95:64]),
                    inv_mix_col(t_blk[63:32]), inv_mix_col(t_blk[31:0])};
        byte_lsb = {~cnt_q[3:0], 3'b000};
    end

    // Next-state logic; enable=0 leaves every register at its current value.
    always_comb begin
        fsm_d   = fsm_q;
        key_d   = key_q;
        ct_d    = ct_q;
        rk_d    = rk_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        ready_d = ready_q;
        out_d   = out_q;
        if (enable) begin
            case (fsm_q)
                IDLE: begin
                    fsm_d  = LOAD;
                    load_d = 1'b1;
                    cnt_d  = 5'd0;
                end
                LOAD: begin
                    key_d[byte_lsb +: 8] = key_byte;
                    ct_d[byte_lsb +: 8]  = state_byte;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q[3:0] == 4'd15) begin
                        load_d = 1'b0;
                        fsm_d  = KEXP;
                        rk_d   = key_d;
                        rnd_d  = 4'd1;
                    end
                end
                KEXP: begin
                    rk_d  = next_rk;
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == 4'd10) begin
                        // k10 only exists on this edge, so whiten with next_rk directly.
                        fsm_d = ROUND;
                        st_d  = ct_q ^ next_rk;
                        rnd_d = 4'd10;
                    end
                end
                ROUND: begin
                    rk_d  = prev_rk;
                    rnd_d = rnd_q - 4'd1;
                    if (rnd_q == 4'd1) begin
                        st_d    = t_blk;
                        fsm_d   = OUT;
                        ready_d = 1'b1;
                        out_d   = t_blk[127:120];
                        cnt_d   = 5'd1;
                    end else begin
                        st_d = imc;
                    end
                end
                OUT: begin
                    if (cnt_q < 5'd16) begin
                        out_d = st_q[byte_lsb +: 8];
                        cnt_d = cnt_q + 5'd1;
                    end else begin
                        ready_d = 1'b0;
                        fsm_d   = IDLE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous reset that overrides enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            key_q   <= '0;
            ct_q    <= '0;
            rk_q    <= '0;
            st_q    <= '0;
            rnd_q   <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            ready_q <= 1'b0;
            out_q   <= 8'h00;
        end else begin
            fsm_q   <= fsm_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            rk_q    <= rk_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            ready_q <= ready_d;
            out_q   <= out_d;
        end
    end

    assign state_out_byte = out_q;
    assign load           = load_q;
    assign ready          = ready_q;
endmodule

// File: tb/tb_aes_decryption.sv
// tb/tb_aes_decryption.sv - randomized self-checking bench for aes_decryption
module tb_aes_decryption;
    logic       clk, rst, enable;
    logic [7:0] key_byte, state_byte, state_out_byte;
    logic       load, ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sbox [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decryption dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .key_byte       (key_byte),
        .state_byte     (state_byte),
        .state_out_byte (state_out_byte),
        .load           (load),
        .ready          (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box table from the generator-3 log walk: p steps by *3, q by /3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    // Textbook AES-128 encryption on a 4x4 byte matrix.
    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-32*c-8*r -: 8] ^ w[c][31-8*r -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd < 10)
                        s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
                end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-32*c-8*r -: 8] = s[r][c];
        return res;
    endfunction

    // Feeds one block, collects the plaintext and watches stalls; runs negedge to negedge.
    // first_ready counts enabled edges from the IDLE edge until ready is first seen.
    task automatic run_block(input logic [127:0] key, input logic [127:0] ct, input int gap_pct,
                             input int abort_at, output logic [127:0] pt, output int nbytes,
                             output int first_ready, output int load_rises, output int freeze_errs,
                             output logic rdy_at_load, output logic timed_out);
        int         nin, e;
        logic       en, en_prev, p_load, p_ready, done;
        logic [7:0] p_out;
        enable = 1'b0;
        nin = 0; e = 0; nbytes = 0; first_ready = 0; load_rises = 0; freeze_errs = 0;
        rdy_at_load = 1'b0; timed_out = 1'b1; pt = '0; done = 1'b0;
        en_prev = 1'b0; p_load = load; p_ready = ready; p_out = state_out_byte;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!en_prev && (load !== p_load || ready !== p_ready || state_out_byte !== p_out))
                freeze_errs++;
            if (load === 1'b1 && p_load !== 1'b1) begin
                load_rises++;
                rdy_at_load = ready;
            end
            if (nin == 16 && ready === 1'b1 && en_prev) begin
                if (nbytes == 0) first_ready = e;
                if (nbytes < 16) pt[127-8*nbytes -: 8] = state_out_byte;
                nbytes++;
            end
            if ((nin == 16 && nbytes >= 16 && ready === 1'b0) || (abort_at > 0 && e == abort_at)) begin
                done = 1'b1;
                timed_out = 1'b0;
            end
            if (done) break;
            p_load = load; p_ready = ready; p_out = state_out_byte;
            en = (int'($urandom_range(99)) < gap_pct) ? 1'b0 : 1'b1;
            enable = en;
            if (load === 1'b1 && en && nin < 16) begin
                key_byte   = key[127-8*nin -: 8];
                state_byte = ct[127-8*nin -: 8];
                nin++;
            end else begin
                key_byte   = 8'($urandom);
                state_byte = 8'($urandom);
            end
            if (en) e++;
            en_prev = en;
        end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 3;
        if (load !== 1'b0) $display("FAIL reset_load: got %b expected 0", load); else n_pass++;
        if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else n_pass++;
        if (state_out_byte !== 8'h00) $display("FAIL reset_out: got %h expected 00", state_out_byte); else n_pass++;
        enable = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fips_c1();
        logic [127:0] pt;
        int nb, fr, lr, fz;
        logic ral, to;
        run_block(C1_KEY, C1_CT, 0, 0, pt, nb, fr, lr, fz, ral, to);
        n_checks += 5;
        if (to !== 1'b0) $display("FAIL c1_timeout: got %b expected 0", to); else n_pass++;
        if (pt !== C1_PT) $display("FAIL c1_plaintext: got %h expected %h", pt, C1_PT); else n_pass++;
        if (nb != 16) $display("FAIL c1_byte_count: got %0d expected 16", nb); else n_pass++;
        if (fr != 37) $display("FAIL c1_latency: got %0d expected 37", fr); else n_pass++;
        if (lr != 1) $display("FAIL c1_load_rises: got %0d expected 1", lr); else n_pass++;
    endtask

    task automatic test_fips_b();
        logic [127:0] pt;
        int nb, fr, lr, fz;
        logic ral, to;
        run_block(B_KEY, B_CT, 0, 0, pt, nb, fr, lr, fz, ral, to);
        n_checks += 2;
        if (pt !== B_PT) $display("FAIL b_plaintext: got %h expected %h", pt, B_PT); else n_pass++;
        if (nb != 16) $display("FAIL b_byte_count: got %0d expected 16", nb); else n_pass++;
    endtask

    task automatic test_stall();
        logic [127:0] pt;
        int nb, fr, lr, fz;
        logic ral, to;
        run_block(C1_KEY, C1_CT, 30, 0, pt, nb, fr, lr, fz, ral, to);
        n_checks += 5;
        if (pt !== C1_PT) $display("FAIL stall_plaintext: got %h expected %h", pt, C1_PT); else n_pass++;
        if (nb != 16) $display("FAIL stall_byte_count: got %0d expected 16", nb); else n_pass++;
        if (fz != 0) $display("FAIL stall_frozen: got %0d changes expected 0", fz); else n_pass++;
        if (fr != 37) $display("FAIL stall_enabled_latency: got %0d expected 37", fr); else n_pass++;
        if (lr != 1) $display("FAIL stall_load_rises: got %0d expected 1", lr); else n_pass++;
    endtask

    // Edge 33 from the IDLE edge is the rnd=5 inverse round; reset lands on it with enable low.
    task automatic test_abort_reset();
        logic [127:0] pt;
        int nb, fr, lr, fz;
        logic ral, to;
        run_block(B_KEY, B_CT, 0, 32, pt, nb, fr, lr, fz, ral, to);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks += 3;
        if (load !== 1'b0) $display("FAIL abort_load: got %b expected 0", load); else n_pass++;
        if (ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", ready); else n_pass++;
        if (state_out_byte !== 8'h00) $display("FAIL abort_out: got %h expected 00", state_out_byte); else n_pass++;
        run_block(B_KEY, B_CT, 0, 0, pt, nb, fr, lr, fz, ral, to);
        n_checks += 2;
        if (pt !== B_PT) $display("FAIL abort_reload_plaintext: got %h expected %h", pt, B_PT); else n_pass++;
        if (nb != 16) $display("FAIL abort_reload_count: got %0d expected 16", nb); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt;
        int nb, fr, lr, fz;
        logic ral, to;
        run_block(C1_KEY, C1_CT, 0, 0, pt, nb, fr, lr, fz, ral, to);
        n_checks += 2;
        if (pt !== C1_PT) $display("FAIL b2b_first_plaintext: got %h expected %h", pt, C1_PT); else n_pass++;
        if (lr != 1) $display("FAIL b2b_first_load_rises: got %0d expected 1", lr); else n_pass++;
        run_block(B_KEY, B_CT, 0, 0, pt, nb, fr, lr, fz, ral, to);
        n_checks += 4;
        if (pt !== B_PT) $display("FAIL b2b_second_plaintext: got %h expected %h", pt, B_PT); else n_pass++;
        if (lr != 1) $display("FAIL b2b_second_load_rises: got %0d expected 1", lr); else n_pass++;
        if (ral !== 1'b0) $display("FAIL b2b_ready_gap: got %b expected 0", ral); else n_pass++;
        if (fr != 37) $display("FAIL b2b_second_latency: got %0d expected 37", fr); else n_pass++;
    endtask

    task automatic test_loopback();
        logic [127:0] key, pt, ct, got;
        int nb, fr, lr, fz;
        logic ral, to;
        n_checks++;
        if (aes_enc(B_KEY, B_PT) !== B_CT) $display("FAIL model_encrypt: got %h expected %h", aes_enc(B_KEY, B_PT), B_CT);
        else n_pass++;
        for (int i = 0; i < 100; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            ct  = aes_enc(key, pt);
            run_block(key, ct, (i % 4 == 0) ? 20 : 0, 0, got, nb, fr, lr, fz, ral, to);
            n_checks++;
            if (got !== pt || nb != 16 || to !== 1'b0)
                $display("FAIL loopback_%0d: got %h (%0d bytes) expected %h", i, got, nb, pt);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        key_byte = 8'h00;
        state_byte = 8'h00;
        build_sbox();
        @(negedge clk);
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_stall();
        test_abort_reset();
        test_back_to_back();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
